// File: rtl/mmu_pkg.sv
// Shared constants for the memory-side responder and the caches that talk to it.
package mmu_pkg;
    localparam logic [7:0] TRSC_GETI = 8'd0;
    localparam logic [7:0] TRSC_GETV = 8'd1;
    localparam logic [7:0] RESP_NONE = 8'd0;
endpackage

// File: rtl/firstk.sv
// Lowest-index set-bit finder (k=1): reports whether any request is set and its index.
module firstk #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Backing-store responder for a cache master port: immediate write acks and
// split-transaction reads (miss handle now, completion on that handle after lat cycles).
module mem_responder
    import mmu_pkg::*;
#(
    parameter int         blk   = 64,
    parameter int         depth = 1024,
    parameter int         lat   = 8,
    parameter int         slots = 4,
    parameter logic [7:0] hid   = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         m_rqst,
    input  logic [7:0]         m_trsc,
    input  logic [blk-1:0]     m_strb,
    input  logic [63:0]        m_addr,
    input  logic [blk*8-1:0]   m_wdat,
    output logic [7:0]         m_resp,
    output logic [7:0]         m_miss,
    output logic [63:0]        m_ofst,
    output logic [blk*8-1:0]   m_rdat
);
    localparam int OW = $clog2(blk);
    localparam int IW = $clog2(depth);
    localparam int CW = $clog2(lat + 1);
    localparam int SW = (slots > 1) ? $clog2(slots) : 1;

    typedef logic [blk-1:0][7:0] line_t;

    line_t                  mem_q [depth];

    logic [slots-1:0]         vld_q;
    logic [slots-1:0][CW-1:0] cnt_q;
    logic [slots-1:0][7:0]    sid_q;
    logic [slots-1:0][7:0]    strc_q;
    logic [slots-1:0][63:0]   sadr_q;

    logic [7:0]  resp_q, resp_d;
    logic [7:0]  miss_q, miss_d;
    logic [63:0] ofst_q, ofst_d;
    line_t       rdat_q, rdat_d;

    logic [slots-1:0] due_vec;
    logic             cmpl, free_any;
    logic [SW-1:0]    due_idx, free_idx;
    logic             acc, do_wr, do_rd;
    line_t            wr_cur, merged, cmp_line;

    always_comb begin
        for (int i = 0; i < slots; i++) due_vec[i] = vld_q[i] && (cnt_q[i] == '0);
    end

    firstk #(.N(slots), .IW(SW)) u_due  (.req_i(due_vec), .found_o(cmpl),     .idx_o(due_idx));
    firstk #(.N(slots), .IW(SW)) u_free (.req_i(~vld_q),  .found_o(free_any), .idx_o(free_idx));

    // Accept only on a quiet output edge so a request still being dropped is not taken twice;
    // a due completion always wins the edge.
    assign acc   = (m_rqst != RESP_NONE) && (resp_q == RESP_NONE) && !cmpl;
    assign do_wr = acc && (m_strb != '0);
    assign do_rd = acc && (m_strb == '0) && free_any;

    assign wr_cur   = mem_q[m_addr[OW +: IW]];
    assign cmp_line = mem_q[sadr_q[due_idx][OW +: IW]];

    always_comb begin
        merged = wr_cur;
        for (int b = 0; b < blk; b++)
            if (m_strb[b]) merged[b] = m_wdat[b*8 +: 8];
    end

    always_comb begin
        resp_d = RESP_NONE;
        miss_d = 8'h00;
        ofst_d = '0;
        rdat_d = '0;
        if (cmpl) begin
            resp_d = hid | 8'(due_idx);
            ofst_d = sadr_q[due_idx];
            rdat_d = cmp_line;
        end else if (do_wr) begin
            resp_d = m_rqst;
            ofst_d = m_addr;
            rdat_d = merged;
        end else if (do_rd) begin
            resp_d = m_rqst;
            miss_d = hid | 8'(free_idx);
            ofst_d = m_addr;
        end
    end

    // Backing array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem_q[m_addr[OW +: IW]] <= merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            sid_q  <= '0;
            strc_q <= '0;
            sadr_q <= '0;
            resp_q <= '0;
            miss_q <= '0;
            ofst_q <= '0;
            rdat_q <= '0;
        end else begin
            for (int i = 0; i < slots; i++)
                if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CW'(1);
            if (cmpl) vld_q[due_idx] <= 1'b0;
            if (do_rd) begin
                vld_q[free_idx]  <= 1'b1;
                cnt_q[free_idx]  <= CW'(lat);
                sid_q[free_idx]  <= m_rqst;
                strc_q[free_idx] <= m_trsc;
                sadr_q[free_idx] <= m_addr;
            end
            resp_q <= resp_d;
            miss_q <= miss_d;
            ofst_q <= ofst_d;
            rdat_q <= rdat_d;
        end
    end

    // Requester ID and transaction type are kept with the slot for debug visibility only.
    logic unused_slot_info;
    assign unused_slot_info = ^{sid_q, strc_q};

    assign m_resp = resp_q;
    assign m_miss = miss_q;
    assign m_ofst = ofst_q;
    assign m_rdat = rdat_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, multi-cycle corner sequences and random traffic
// checked against a line-level memory model with a handle pool.
module tb_mem_responder;
    localparam int         BLK   = 64;
    localparam int         DEPTH = 1024;
    localparam int         LAT   = 8;
    localparam int         SLOTS = 4;
    localparam logic [7:0] HID   = 8'hF0;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     m_rqst, m_trsc, m_resp, m_miss;
    logic [BLK-1:0] m_strb;
    logic [63:0]    m_addr, m_ofst;
    logic [511:0]   m_wdat, m_rdat;

    mem_responder #(.blk(BLK), .depth(DEPTH), .lat(LAT), .slots(SLOTS), .hid(HID)) dut (
        .clk(clk), .rst(rst), .m_rqst(m_rqst), .m_trsc(m_trsc), .m_strb(m_strb),
        .m_addr(m_addr), .m_wdat(m_wdat), .m_resp(m_resp), .m_miss(m_miss),
        .m_ofst(m_ofst), .m_rdat(m_rdat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    // Model: line contents by index, handle pool, pending request bookkeeping.
    logic [511:0] mdl [int];
    bit           busy [SLOTS];
    logic [63:0]  hadr [SLOTS];
    int           hcyc [SLOTS];
    bit           mon_en = 1'b0;
    logic [7:0]   cur_id = 8'h00;
    bit           cur_acked = 1'b1;
    logic [7:0]   ack_miss;
    logic [63:0]  ack_ofst;
    logic [511:0] ack_rdat;
    int           ack_cyc;
    int           last_cmpl_cyc = -1;
    logic [7:0]   last_cmpl_h;
    logic [511:0] last_cmpl_rdat;
    int           npulse = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lidx(input logic [63:0] a);
        return int'(a[15:6]);
    endfunction

    function automatic logic [511:0] merge(input logic [511:0] old, input logic [63:0] st,
                                           input logic [511:0] wd);
        logic [511:0] r;
        r = old;
        for (int b = 0; b < 64; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic int lowest_free();
        for (int s = 0; s < SLOTS; s++) if (!busy[s]) return s;
        return -1;
    endfunction

    function automatic logic [511:0] mkline(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] rest);
        logic [511:0] r;
        r = {64{rest}};
        r[7:0]  = b0;
        r[15:8] = b1;
        return r;
    endfunction

    // Response monitor: completions checked against the model, acks latched for the driver.
    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (mon_en && m_resp != 8'h00) begin
                npulse++;
                if (m_resp >= HID && int'(m_resp) < int'(HID) + SLOTS) begin
                    s = int'(m_resp - HID);
                    if (!busy[s]) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cmpl: got resp=%0h, expected no completion", m_resp);
                    end else begin
                        chk("cmpl_miss", m_miss, 0);
                        chk("cmpl_ofst", m_ofst, hadr[s]);
                        if (mdl.exists(lidx(hadr[s]))) chk("cmpl_rdat", m_rdat, mdl[lidx(hadr[s])]);
                        checks++;
                        if (cyc - hcyc[s] < LAT + 1) begin
                            errors++;
                            $display("FAIL cmpl_early: got %0d cycles, expected >= %0d", cyc - hcyc[s], LAT + 1);
                        end
                        busy[s]        = 1'b0;
                        last_cmpl_cyc  = cyc;
                        last_cmpl_h    = m_resp;
                        last_cmpl_rdat = m_rdat;
                    end
                end else if (m_resp == cur_id && !cur_acked) begin
                    cur_acked = 1'b1;
                    ack_miss  = m_miss;
                    ack_ofst  = m_ofst;
                    ack_rdat  = m_rdat;
                    ack_cyc   = cyc;
                end else begin
                    checks++; errors++;
                    $display("FAIL spurious_resp: got resp=%0h, expected none (pending id %0h)", m_resp, cur_id);
                end
            end
        end
    end

    // Present one request, hold it until acked, then check the ack against the model.
    task automatic do_req(input logic [7:0] id, input logic [63:0] a, input logic [63:0] st,
                          input logic [511:0] wd);
        int s;
        bit got;
        logic [511:0] exp_line;
        cur_id = id; cur_acked = 1'b0; got = 1'b0;
        m_rqst = id; m_trsc = 8'($urandom_range(0, 1)); m_strb = st; m_addr = a; m_wdat = wd;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk); #1;
            got = cur_acked;
        end
        m_rqst = 8'h00; m_strb = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no resp, expected resp=%0h", id);
            return;
        end
        chk("ack_ofst", ack_ofst, a);
        if (st != 64'h0) begin
            exp_line = mdl.exists(lidx(a)) ? mdl[lidx(a)] : 512'h0;
            exp_line = merge(exp_line, st, wd);
            chk("wr_miss", ack_miss, 0);
            chk("wr_rdat", ack_rdat, exp_line);
            mdl[lidx(a)] = exp_line;
        end else begin
            s = lowest_free();
            if (s < 0) begin
                checks++; errors++;
                $display("FAIL rd_ack_when_full: got miss=%0h, expected no response", ack_miss);
            end else begin
                chk("rd_miss", ack_miss, HID | 8'(s));
                busy[s] = 1'b1; hadr[s] = a; hcyc[s] = ack_cyc;
            end
            chk("rd_rdat", ack_rdat, 0);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge clk); #1;
            idle = (lowest_free() == 0) && !busy[1] && !busy[2] && !busy[3];
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL drain_timeout: got reads still outstanding, expected all completed");
        end
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [63:0] strb;
        logic [7:0]  wb0, wb1, wr;
        logic [7:0]  emiss;
        logic [7:0]  eb0, eb1, er;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #800_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] wd, old_line;
        int c0, cm;
        logic [63:0] a, st;

        tbl[0] = '{8'h01, 64'h40,    ALL1,  8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5};
        tbl[1] = '{8'h02, 64'h40,    64'h0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hA5, 8'hA5, 8'hA5};
        tbl[2] = '{8'h03, 64'h40,    64'h3, 8'h11, 8'h22, 8'hEE, 8'h00, 8'h11, 8'h22, 8'hA5};
        tbl[3] = '{8'h04, 64'h7F,    64'h0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h11, 8'h22, 8'hA5};
        tbl[4] = '{8'h05, 64'h80,    ALL1,  8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 8'h3C};
        tbl[5] = '{8'h06, 64'h10040, 64'h0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h11, 8'h22, 8'hA5};
        tbl[6] = '{8'h07, 64'h80,    64'h2, 8'h00, 8'h99, 8'h77, 8'h00, 8'h3C, 8'h99, 8'h3C};
        tbl[7] = '{8'h08, 64'h80,    64'h0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h3C, 8'h99, 8'h3C};

        // Reset with a request already presented: silent during reset, ack one cycle after release.
        rst = 1'b1; m_rqst = 8'h05; m_trsc = 8'h00; m_strb = ALL1; m_addr = 64'h0;
        m_wdat = {64{8'h5A}};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rst_resp", m_resp, 0); chk("rst_miss", m_miss, 0); chk("rst_rdat", m_rdat, 0);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_first_ack", m_resp, 8'h05);
        chk("rst_first_miss", m_miss, 0);
        chk("rst_first_rdat", m_rdat, {64{8'h5A}});
        m_rqst = 8'h00; m_strb = '0;
        mdl[0] = {64{8'h5A}};
        @(negedge clk); #1;
        mon_en = 1'b1;

        for (int ln = 0; ln < 32; ln++) do_req(8'h30, 64'(ln) << 6, ALL1, rnd_line());

        // Directed vectors, each run to completion with exact read latency.
        for (int i = 0; i < 8; i++) begin
            wd = mkline(tbl[i].wb0, tbl[i].wb1, tbl[i].wr);
            do_req(tbl[i].id, tbl[i].addr, tbl[i].strb, wd);
            chk("vec_miss", ack_miss, tbl[i].emiss);
            if (tbl[i].strb != 64'h0) begin
                chk("vec_wr_rdat", ack_rdat, mkline(tbl[i].eb0, tbl[i].eb1, tbl[i].er));
            end else begin
                drain();
                chk("vec_cmpl_h", last_cmpl_h, tbl[i].emiss);
                chk("vec_cmpl_lat", 32'(last_cmpl_cyc - ack_cyc), LAT + 1);
                chk("vec_cmpl_rdat", last_cmpl_rdat, mkline(tbl[i].eb0, tbl[i].eb1, tbl[i].er));
            end
        end

        // All slots busy: the fifth read is held until slot 0 completes, then reuses F0.
        for (int i = 0; i < 4; i++) begin
            do_req(8'(i + 1), 64'(8 + i) << 6, 64'h0, 512'h0);
            chk("full_handle", ack_miss, HID + 8'(i));
        end
        c0 = cyc;
        do_req(8'h05, 64'(12) << 6, 64'h0, 512'h0);
        chk("full_reuse_h", ack_miss, HID);
        checks++;
        if (!(last_cmpl_cyc > c0 && last_cmpl_cyc < ack_cyc)) begin
            errors++;
            $display("FAIL full_wait: got ack at %0d after last completion %0d, expected ack after slot freed", ack_cyc, last_cmpl_cyc);
        end
        drain();

        // Write arrives on the very edge a completion is due: completion first, write two cycles later.
        old_line = mdl[20];
        do_req(8'h10, 64'(20) << 6, 64'h0, 512'h0);
        repeat (LAT) @(negedge clk);
        #1;
        wd = rnd_line();
        do_req(8'h06, 64'(20) << 6, ALL1, wd);
        chk("coll_order", 32'(ack_cyc - last_cmpl_cyc), 2);
        chk("coll_old_data", last_cmpl_rdat, old_line);
        do_req(8'h11, 64'(20) << 6, 64'h0, 512'h0);
        drain();
        chk("coll_write_kept", last_cmpl_rdat, wd);

        // Reset with two reads in flight: nothing completes afterwards, handles restart at F0.
        do_req(8'h21, 64'(21) << 6, 64'h0, 512'h0);
        do_req(8'h22, 64'(22) << 6, 64'h0, 512'h0);
        rst = 1'b1;
        for (int s = 0; s < SLOTS; s++) busy[s] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        cm = npulse;
        repeat (LAT + 10) @(negedge clk);
        #1;
        chk("rst_no_cmpl", npulse - cm, 0);
        do_req(8'h23, 64'(23) << 6, 64'h0, 512'h0);
        chk("rst_new_h", ack_miss, HID);
        drain();

        // Random traffic on four lines with address aliasing and random strobes.
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            a = (64'(16 + $urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63))
                | ({32'($urandom), 32'h0} & 64'hFFFF_FFFF_0001_0000);
            st = ($urandom_range(0, 1) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
            do_req(8'($urandom_range(1, 8'hEF)), a, st, rnd_line());
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
